// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter with byte FIFO and runtime baud period
module uart_tx #(
    parameter int DEPTH = 4,
    parameter int CPB_W = 15
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [CPB_W-1:0]         clks_per_bit_i,
    input  logic                     in_valid_i,
    input  logic [7:0]               in_data_i,
    output logic                     in_ready_o,
    output logic                     tx_o,
    output logic                     busy_o,
    output logic                     tx_done_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    state_t           state;
    state_t           state_next;

    logic [CPB_W-1:0] cpb_eff;
    logic [CPB_W-1:0] cpb_lat;
    logic [CPB_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic             bit_end;

    // A period below two cycles cannot be counted down, so clamp it
    assign cpb_eff    = (clks_per_bit_i < CPB_W'(2)) ? CPB_W'(2) : clks_per_bit_i;
    assign fifo_empty = (count == '0);
    assign push       = in_valid_i & in_ready_o;
    assign bit_end    = (baud_cnt == '0);
    assign fifo_count_o = count;

    // Occupancy after this edge; ready already blocks pushes while full
    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // FIFO pointers, occupancy and registered status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_o <= 1'b1;
            busy_o     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_next;
            in_ready_o <= (count_next != CNT_W'(DEPTH));
            busy_o     <= (state_next != IDLE) || (count_next != '0);
        end
    end

    // FIFO storage; contents are don't-care after a flush
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= in_data_i;
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next state; a pop happens on frame entry from IDLE or straight out of STOP
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs: line level per state and end-of-stop pulse
    always_comb begin
        tx_o      = 1'b1;
        tx_done_o = 1'b0;
        case (state)
            IDLE:    tx_o = 1'b1;
            START:   tx_o = 1'b0;
            DATA:    tx_o = shift[0];
            STOP: begin
                tx_o      = 1'b1;
                tx_done_o = bit_end;
            end
            default: tx_o = 1'b1;
        endcase
    end

    // Bit timing and shift register; period is captured once per frame
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpb_lat  <= CPB_W'(2);
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (pop) begin
            shift    <= mem[rd_ptr];
            cpb_lat  <= cpb_eff;
            baud_cnt <= cpb_eff - CPB_W'(1);
            bit_idx  <= '0;
        end else if (state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= cpb_lat - CPB_W'(1);
                if (state == DATA) begin
                    bit_idx <= bit_idx + 3'd1;
                    shift   <= {1'b0, shift[7:1]};
                end
            end else begin
                baud_cnt <= baud_cnt - CPB_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;

    localparam int DEPTH = 4;
    localparam int CPB_W = 15;
    localparam int N     = 1024;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [CPB_W-1:0] cpb   = CPB_W'(4);
    logic             in_valid = 1'b0;
    logic [7:0]       in_data  = 8'h00;
    logic             ready;
    logic             tx;
    logic             busy;
    logic             done;
    logic [2:0]       count;

    int vectors     = 0;
    int miscompares = 0;

    // Per-cycle stimulus schedule: values presented before edge c
    logic             sched_valid [N];
    logic [7:0]       sched_data  [N];
    logic [CPB_W-1:0] sched_cpb   [N];

    // Outputs sampled on the falling edge after edge c
    logic             tr_tx    [N];
    logic             tr_done  [N];
    logic             tr_busy  [N];
    logic             tr_ready [N];
    logic [2:0]       tr_count [N];

    // Hand-derived expected waveforms
    logic             exp_tx   [N];
    logic             exp_done [N];
    logic             exp_busy [N];

    uart_tx #(.DEPTH(DEPTH), .CPB_W(CPB_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .clks_per_bit_i (cpb),
        .in_valid_i     (in_valid),
        .in_data_i      (in_data),
        .in_ready_o     (ready),
        .tx_o           (tx),
        .busy_o         (busy),
        .tx_done_o      (done),
        .fifo_count_o   (count)
    );

    always #5 clock = ~clock;

    task automatic clear_sched(input int p);
        for (int i = 0; i < N; i++) begin
            sched_valid[i] = 1'b0;
            sched_data[i]  = 8'h00;
            sched_cpb[i]   = CPB_W'(p);
        end
    endtask

    task automatic sched_push(input int c, input logic [7:0] b);
        sched_valid[c] = 1'b1;
        sched_data[c]  = b;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            in_valid = sched_valid[c];
            in_data  = sched_data[c];
            cpb      = sched_cpb[c];
            @(posedge clock);
            @(negedge clock);
            tr_tx[c]    = tx;
            tr_done[c]  = done;
            tr_busy[c]  = busy;
            tr_ready[c] = ready;
            tr_count[c] = count;
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_idle();
        for (int i = 0; i < N; i++) begin
            exp_tx[i]   = 1'b1;
            exp_done[i] = 1'b0;
            exp_busy[i] = 1'b0;
        end
    endtask

    // One 8N1 frame whose first (start) cycle is s, p cycles per bit
    task automatic paint(input int s, input logic [7:0] b, input int p);
        int slot;
        for (int t = 0; t < 10 * p; t++) begin
            slot = t / p;
            if (slot == 0)      exp_tx[s + t] = 1'b0;
            else if (slot == 9) exp_tx[s + t] = 1'b1;
            else                exp_tx[s + t] = b[slot - 1];
        end
        exp_done[s + 10 * p - 1] = 1'b1;
    endtask

    task automatic paint_busy(input int from, input int to);
        for (int i = from; i <= to; i++) exp_busy[i] = 1'b1;
    endtask

    function automatic logic tr_val(input int k, input int i);
        case (k)
            0:       return tr_tx[i];
            1:       return tr_done[i];
            default: return tr_busy[i];
        endcase
    endfunction

    function automatic logic exp_val(input int k, input int i);
        case (k)
            0:       return exp_tx[i];
            1:       return exp_done[i];
            default: return exp_busy[i];
        endcase
    endfunction

    // First cycle where a recorded signal departs from its expectation, or -1
    function automatic int trace_diff(input int k, input int n);
        for (int i = 0; i < n; i++)
            if (tr_val(k, i) !== exp_val(k, i)) return i;
        return -1;
    endfunction

    task automatic test_reset();
        @(negedge clock);
        vectors++; if (tx !== 1'b1)    begin miscompares++; $display("FAIL reset_tx: got %b want 1", tx); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)  begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_a5();
        logic [9:0] bits;
        int d;
        bits = 10'b1101001010;
        clear_sched(87);
        sched_push(0, 8'hA5);
        expect_idle();
        paint(1, 8'hA5, 87);
        paint_busy(0, 870);
        run(880);
        vectors++; if (tr_tx[0] !== 1'b1) begin miscompares++; $display("FAIL a5_tx_c0: got %b want 1", tr_tx[0]); end
        vectors++; if (tr_tx[1] !== 1'b0) begin miscompares++; $display("FAIL a5_tx_fall: got %b want 0", tr_tx[1]); end
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (tr_tx[43 + 87 * k] !== bits[k]) begin
                miscompares++;
                $display("FAIL a5_bit%0d: got %b want %b", k, tr_tx[43 + 87 * k], bits[k]);
            end
        end
        vectors++; if (tr_done[869] !== 1'b0) begin miscompares++; $display("FAIL a5_done_869: got %b want 0", tr_done[869]); end
        vectors++; if (tr_done[870] !== 1'b1) begin miscompares++; $display("FAIL a5_done_870: got %b want 1", tr_done[870]); end
        vectors++; if (tr_busy[870] !== 1'b1) begin miscompares++; $display("FAIL a5_busy_870: got %b want 1", tr_busy[870]); end
        vectors++; if (tr_busy[871] !== 1'b0) begin miscompares++; $display("FAIL a5_busy_871: got %b want 0", tr_busy[871]); end
        for (int k = 0; k < 3; k++) begin
            d = trace_diff(k, 880);
            vectors++;
            if (d !== -1) begin
                miscompares++;
                $display("FAIL a5_trace_sig%0d: cycle %0d got %b want %b", k, d, tr_val(k, d), exp_val(k, d));
            end
        end
    endtask

    task automatic test_fill_full();
        int d;
        clear_sched(4);
        sched_push(0, 8'h55);
        sched_push(1, 8'h00);
        sched_push(2, 8'hFF);
        sched_push(3, 8'h3C);
        sched_push(4, 8'h11);
        sched_push(5, 8'h22);
        expect_idle();
        paint(1,   8'h55, 4);
        paint(41,  8'h00, 4);
        paint(81,  8'hFF, 4);
        paint(121, 8'h3C, 4);
        paint(161, 8'h11, 4);
        paint_busy(0, 200);
        run(250);
        vectors++; if (tr_count[4] !== 3'd4)  begin miscompares++; $display("FAIL full_count_c4: got %0d want 4", tr_count[4]); end
        vectors++; if (tr_ready[4] !== 1'b0)  begin miscompares++; $display("FAIL full_ready_c4: got %b want 0", tr_ready[4]); end
        vectors++; if (tr_count[5] !== 3'd4)  begin miscompares++; $display("FAIL full_count_c5: got %0d want 4", tr_count[5]); end
        vectors++; if (tr_count[40] !== 3'd4) begin miscompares++; $display("FAIL full_count_c40: got %0d want 4", tr_count[40]); end
        vectors++; if (tr_count[41] !== 3'd3) begin miscompares++; $display("FAIL full_count_c41: got %0d want 3", tr_count[41]); end
        for (int k = 0; k < 3; k++) begin
            d = trace_diff(k, 250);
            vectors++;
            if (d !== -1) begin
                miscompares++;
                $display("FAIL full_trace_sig%0d: cycle %0d got %b want %b", k, d, tr_val(k, d), exp_val(k, d));
            end
        end
    endtask

    task automatic test_cpb_clamp();
        int d;
        for (int p = 0; p < 2; p++) begin
            clear_sched(p);
            sched_push(0, 8'h80);
            expect_idle();
            paint(1, 8'h80, 2);
            paint_busy(0, 20);
            run(30);
            vectors++; if (tr_tx[16] !== 1'b0)  begin miscompares++; $display("FAIL clamp%0d_c16: got %b want 0", p, tr_tx[16]); end
            vectors++; if (tr_tx[17] !== 1'b1)  begin miscompares++; $display("FAIL clamp%0d_c17: got %b want 1", p, tr_tx[17]); end
            vectors++; if (tr_done[20] !== 1'b1) begin miscompares++; $display("FAIL clamp%0d_done: got %b want 1", p, tr_done[20]); end
            for (int k = 0; k < 3; k++) begin
                d = trace_diff(k, 30);
                vectors++;
                if (d !== -1) begin
                    miscompares++;
                    $display("FAIL clamp%0d_trace_sig%0d: cycle %0d got %b want %b", p, k, d, tr_val(k, d), exp_val(k, d));
                end
            end
        end
    endtask

    task automatic test_cpb_change();
        int d;
        clear_sched(10);
        for (int c = 30; c < N; c++) sched_cpb[c] = CPB_W'(20);
        sched_push(0, 8'h3C);
        sched_push(1, 8'hC3);
        expect_idle();
        paint(1,   8'h3C, 10);
        paint(101, 8'hC3, 20);
        paint_busy(0, 300);
        run(310);
        vectors++; if (tr_done[100] !== 1'b1) begin miscompares++; $display("FAIL chg_done_100: got %b want 1", tr_done[100]); end
        vectors++; if (tr_done[300] !== 1'b1) begin miscompares++; $display("FAIL chg_done_300: got %b want 1", tr_done[300]); end
        for (int k = 0; k < 3; k++) begin
            d = trace_diff(k, 310);
            vectors++;
            if (d !== -1) begin
                miscompares++;
                $display("FAIL chg_trace_sig%0d: cycle %0d got %b want %b", k, d, tr_val(k, d), exp_val(k, d));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int d;
        clear_sched(8);
        sched_push(0, 8'h00);
        sched_push(1, 8'hF0);
        sched_push(2, 8'h0F);
        run(38);
        vectors++; if (tr_tx[37] !== 1'b0)    begin miscompares++; $display("FAIL rst_pre_tx: got %b want 0", tr_tx[37]); end
        vectors++; if (tr_count[37] !== 3'd2) begin miscompares++; $display("FAIL rst_pre_count: got %0d want 2", tr_count[37]); end
        reset = 1'b1;
        #1;
        vectors++; if (tx !== 1'b1)    begin miscompares++; $display("FAIL rst_tx: got %b want 1", tx); end
        vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count: got %0d want 0", count); end
        vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b want 1", ready); end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        clear_sched(8);
        expect_idle();
        run(100);
        for (int k = 0; k < 3; k++) begin
            d = trace_diff(k, 100);
            vectors++;
            if (d !== -1) begin
                miscompares++;
                $display("FAIL rst_after_sig%0d: cycle %0d got %b want %b", k, d, tr_val(k, d), exp_val(k, d));
            end
        end
    endtask

    task automatic test_back_to_back();
        int d;
        clear_sched(4);
        sched_push(0,  8'h12);
        sched_push(1,  8'h34);
        sched_push(2,  8'h56);
        sched_push(3,  8'h78);
        sched_push(41, 8'h9A);
        expect_idle();
        paint(1,   8'h12, 4);
        paint(41,  8'h34, 4);
        paint(81,  8'h56, 4);
        paint(121, 8'h78, 4);
        paint(161, 8'h9A, 4);
        paint_busy(0, 200);
        run(250);
        vectors++; if (tr_count[40] !== 3'd3) begin miscompares++; $display("FAIL b2b_count_c40: got %0d want 3", tr_count[40]); end
        vectors++; if (tr_ready[40] !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_c40: got %b want 1", tr_ready[40]); end
        vectors++; if (tr_count[41] !== 3'd3) begin miscompares++; $display("FAIL b2b_count_c41: got %0d want 3", tr_count[41]); end
        for (int k = 0; k < 3; k++) begin
            d = trace_diff(k, 250);
            vectors++;
            if (d !== -1) begin
                miscompares++;
                $display("FAIL b2b_trace_sig%0d: cycle %0d got %b want %b", k, d, tr_val(k, d), exp_val(k, d));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_fill_full();
        test_cpb_clamp();
        test_cpb_change();
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
